// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I opcode, control-bundle and rs-usage definitions
package core_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [1:0] ALUOP_JMP   = 2'b11;

  localparam logic [1:0] RW_ALU   = 2'b00;
  localparam logic [1:0] RW_PC4   = 2'b01;
  localparam logic [1:0] RW_IMM   = 2'b10;
  localparam logic [1:0] RW_PCIMM = 2'b11;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       branch;
    logic       jalr_sel;
    logic [1:0] rw_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // U-type and JAL carry no rs1 field; everything else reads it
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector for the ID/EX boundary
module load_use_detect
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              reset,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush,
  output logic              hazard,
  output logic              stall_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = uses_rs1(id_opcode) && (id_rs1 == ex_rd);
  assign rs2_hit = uses_rs2(id_opcode) && (id_rs2 == ex_rd);

  // a load into x0 produces nothing to wait for
  assign hazard  = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  assign stall_o = hazard && !flush && !reset;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, flush and perf counters
module id_ex_stage
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic              id_alu_src,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_jalr_sel,
  input  logic [1:0]        id_alu_op,
  input  logic [1:0]        id_rw_sel,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              flush,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jalr_sel,
  output logic [1:0]        ex_alu_op,
  output logic [1:0]        ex_rw_sel,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              ex_valid,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hazard;

  always_comb begin
    id_ctrl            = CTRL_NOP;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.alu_op     = id_alu_op;
    id_ctrl.branch     = id_branch;
    id_ctrl.jalr_sel   = id_jalr_sel;
    id_ctrl.rw_sel     = id_rw_sel;
  end

  load_use_detect #(.REG_AW(REG_AW)) u_detect (
    .reset       (reset),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .hazard      (hazard),
    .stall_o     (stall_o)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= CTRL_NOP;
      ex_pc      <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_funct3  <= '0;
      ex_funct7  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (flush || hazard) begin
      // squash or bubble look identical in EX; only the counter differs
      ex_valid  <= 1'b0;
      ex_ctrl   <= CTRL_NOP;
      ex_pc     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct3 <= '0;
      ex_funct7 <= '0;
      if (flush) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else begin
      ex_valid  <= id_valid;
      ex_ctrl   <= id_valid ? id_ctrl : CTRL_NOP;
      ex_pc     <= id_pc;
      ex_rd1    <= id_rd1;
      ex_rd2    <= id_rd2;
      ex_imm    <= id_imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_funct3 <= id_funct3;
      ex_funct7 <= id_funct7;
    end
  end

  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_jalr_sel   = ex_ctrl.jalr_sel;
  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_rw_sel     = ex_ctrl.rw_sel;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int K_LOAD = 0, K_BUBBLE = 1, K_FLUSH = 2, K_RESET = 3;

  localparam logic [10:0] C_ADD  = 11'b00100_00_10_00;
  localparam logic [10:0] C_LW   = 11'b11110_00_00_00;
  localparam logic [10:0] C_SW   = 11'b10001_00_00_00;
  localparam logic [10:0] C_LUI  = 11'b10100_00_00_10;
  localparam logic [10:0] C_ADDI = 11'b10100_00_10_00;

  logic clk = 1'b0;
  logic reset, id_valid, flush;
  logic [6:0]  id_opcode, id_funct7;
  logic        id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jalr_sel;
  logic [1:0]  id_alu_op, id_rw_sel;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;

  logic        ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jalr_sel;
  logic [1:0]  ex_alu_op, ex_rw_sel;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic        ex_valid, stall_o;
  logic [15:0] bubble_cnt, flush_cnt;

  logic        s_alu_src, s_mem_to_reg, s_reg_write, s_mem_read, s_mem_write, s_branch, s_jalr_sel;
  logic [1:0]  s_alu_op, s_rw_sel;
  logic [31:0] s_pc, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [2:0]  s_funct3;
  logic [6:0]  s_funct7;
  logic        s_valid, s_stall;
  logic [1:0]  s_bubble_cnt, s_flush_cnt;

  int errors = 0;
  int checks = 0;
  logic [164:0] exp_q[$];
  int exp_bub = 0;
  int exp_fl  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jalr_sel(id_jalr_sel), .id_alu_op(id_alu_op), .id_rw_sel(id_rw_sel),
    .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .flush(flush),
    .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jalr_sel(ex_jalr_sel), .ex_alu_op(ex_alu_op), .ex_rw_sel(ex_rw_sel),
    .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_valid(ex_valid), .stall_o(stall_o), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jalr_sel(id_jalr_sel), .id_alu_op(id_alu_op), .id_rw_sel(id_rw_sel),
    .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .flush(flush),
    .ex_alu_src(s_alu_src), .ex_mem_to_reg(s_mem_to_reg), .ex_reg_write(s_reg_write),
    .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write), .ex_branch(s_branch),
    .ex_jalr_sel(s_jalr_sel), .ex_alu_op(s_alu_op), .ex_rw_sel(s_rw_sel),
    .ex_pc(s_pc), .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct3(s_funct3), .ex_funct7(s_funct7),
    .ex_valid(s_valid), .stall_o(s_stall), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [164:0] obs, input logic [164:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [164:0] in_vec();
    logic [10:0] c;
    c = {id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write,
         id_branch, id_jalr_sel, id_alu_op, id_rw_sel};
    return {id_valid, id_valid ? c : 11'b0, id_pc, id_rd1, id_rd2, id_imm,
            id_rs1, id_rs2, id_rd, id_funct3, id_funct7};
  endfunction

  function automatic logic [164:0] obs_vec();
    return {ex_valid, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write,
            ex_branch, ex_jalr_sel, ex_alu_op, ex_rw_sel, ex_pc, ex_rd1, ex_rd2, ex_imm,
            ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7};
  endfunction

  task automatic set_in(input logic v, input logic [6:0] op, input logic [10:0] c,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid  = v;
    id_opcode = op;
    {id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write,
     id_branch, id_jalr_sel, id_alu_op, id_rw_sel} = c;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_pc  = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
  endtask

  // inputs are already driven at a falling edge; check stall, clock once, then check EX
  task automatic step(input string tag, input int kind, input logic exp_stall);
    logic [164:0] e;
    #1;
    check({tag, " stall"}, 165'(stall_o), 165'(exp_stall));
    if (kind == K_LOAD) exp_q.push_back(in_vec());
    else exp_q.push_back('0);
    if (kind == K_BUBBLE) exp_bub++;
    if (kind == K_FLUSH) exp_fl++;
    if (kind == K_RESET) begin exp_bub = 0; exp_fl = 0; end
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, " ex"}, obs_vec(), e);
    check({tag, " cnt"}, {133'b0, bubble_cnt, flush_cnt}, {133'b0, 16'(exp_bub), 16'(exp_fl)});
  endtask

  logic [1:0] sat_seq [5];

  initial begin
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset = 1'b1;
    flush = 1'b0;
    set_in(1'b0, 7'h0, 11'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);

    // 1: reset with random inputs, then a valid add
    for (int i = 0; i < 2; i++) begin
      set_in(1'($urandom), 7'($urandom), 11'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      flush = 1'($urandom);
      step("reset", K_RESET, 1'b0);
    end
    check("reset small cnt", {161'b0, s_bubble_cnt, s_flush_cnt}, '0);
    reset = 1'b0;
    flush = 1'b0;
    set_in(1'b1, OP_RTYPE, C_ADD, 5'd1, 5'd2, 5'd3);
    step("add load", K_LOAD, 1'b0);
    set_in(1'b0, OP_RTYPE, C_ADD, 5'd4, 5'd5, 5'd6);
    step("invalid load", K_LOAD, 1'b0);

    // 2: load-use on rs1
    set_in(1'b1, OP_LOAD, C_LW, 5'd2, 5'd0, 5'd5);
    step("lw x5", K_LOAD, 1'b0);
    set_in(1'b1, OP_RTYPE, C_ADD, 5'd5, 5'd7, 5'd6);
    step("add x5 bubble", K_BUBBLE, 1'b1);
    step("add x5 reload", K_LOAD, 1'b0);

    // 3: x0, non-reading opcodes, store rs2, unused rs2 field
    set_in(1'b1, OP_LOAD, C_LW, 5'd2, 5'd0, 5'd0);
    step("lw x0", K_LOAD, 1'b0);
    set_in(1'b1, OP_RTYPE, C_ADD, 5'd0, 5'd0, 5'd6);
    step("add x0", K_LOAD, 1'b0);
    set_in(1'b1, OP_LOAD, C_LW, 5'd2, 5'd0, 5'd5);
    step("lw x5 b", K_LOAD, 1'b0);
    set_in(1'b1, OP_LUI, C_LUI, 5'd5, 5'd5, 5'd5);
    step("lui x5", K_LOAD, 1'b0);
    set_in(1'b1, OP_LOAD, C_LW, 5'd2, 5'd0, 5'd5);
    step("lw x5 c", K_LOAD, 1'b0);
    set_in(1'b1, OP_STORE, C_SW, 5'd1, 5'd5, 5'd0);
    step("sw rs2 bubble", K_BUBBLE, 1'b1);
    step("sw rs2 reload", K_LOAD, 1'b0);
    set_in(1'b1, OP_LOAD, C_LW, 5'd2, 5'd0, 5'd5);
    step("lw x5 d", K_LOAD, 1'b0);
    set_in(1'b1, OP_ITYPE, C_ADDI, 5'd2, 5'd5, 5'd3);
    step("addi rs2 field", K_LOAD, 1'b0);

    // 4: flush and hazard together
    set_in(1'b1, OP_LOAD, C_LW, 5'd2, 5'd0, 5'd5);
    step("lw x5 e", K_LOAD, 1'b0);
    set_in(1'b1, OP_RTYPE, C_ADD, 5'd5, 5'd7, 5'd6);
    flush = 1'b1;
    step("flush+hazard", K_FLUSH, 1'b0);
    flush = 1'b0;
    step("after flush", K_LOAD, 1'b0);

    // 6: reset in the middle of a stall
    set_in(1'b1, OP_LOAD, C_LW, 5'd2, 5'd0, 5'd5);
    step("lw x5 f", K_LOAD, 1'b0);
    set_in(1'b1, OP_RTYPE, C_ADD, 5'd5, 5'd7, 5'd6);
    #1;
    check("pre-reset stall", 165'(stall_o), 165'(1'b1));
    reset = 1'b1;
    step("reset in stall", K_RESET, 1'b0);
    reset = 1'b0;
    step("re-present add", K_LOAD, 1'b0);

    // 5: saturation of the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, OP_LOAD, C_LW, 5'd2, 5'd0, 5'd5);
      step("sat lw", K_LOAD, 1'b0);
      set_in(1'b1, OP_RTYPE, C_ADD, 5'd5, 5'd7, 5'd6);
      step("sat bubble", K_BUBBLE, 1'b1);
      check("sat small cnt", {163'b0, s_bubble_cnt}, {163'b0, sat_seq[i]});
    end
    check("sat small flush", {163'b0, s_flush_cnt}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage RV32I core. Sits directly downstream of the main decode controller and register file.
- Registers the decoded control bundle, operands, immediate and register indices into EX.
- Contains the load-use hazard detector. Its stall_o output freezes PC and IF/ID while the stage injects a bubble.
- Handles flush from EX (taken branch / jal / jalr).
- Keeps saturating bubble and flush counters for performance debug.

Parameters:
- DATA_W, 32, width of operands, immediate, PC
- REG_AW, 5, register index width
- CNT_W, 16, width of bubble/flush performance counters

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  opcode of ID instruction (used for rs-usage decode)
- id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jalr_sel  in  1 each  controller outputs
- id_alu_op  in  2  controller ALUOp
- id_rw_sel  in  2  controller write-back select
- id_pc, id_rd1, id_rd2, id_imm  in  DATA_W each  PC, register read data, immediate
- id_rs1, id_rs2, id_rd  in  REG_AW each  register indices
- id_funct3  in  3;  id_funct7  in  7  ALU-control fields
- flush  in  1  squash the ID instruction (EX redirect)
- ex_*  out  (same widths as the matching id_* inputs, excluding id_opcode)  registered EX copies
- ex_valid  out  1  EX holds a real instruction
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt, flush_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset (sync):
  - All ex_* fields = 0 and ex_valid = 0.
  - bubble_cnt = flush_cnt = 0.
  - stall_o = 0 while reset is high.
- rs usage, decoded from id_opcode:
  - uses_rs1 = 1 for every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - uses_rs2 = 1 only for R-type 0110011, STORE 0100011 and BRANCH 1100011.
- hazard (comb) = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)).
- stall_o = hazard & ~flush & ~reset.
- Per-edge priority, reset > flush > hazard > load:
  - flush: ex_valid <= 0; all ex control bits and ex_alu_op / ex_rw_sel <= 0; data/index fields <= 0. flush_cnt += 1, saturating.
  - hazard (no flush): bubble. Same zeroing as flush; bubble_cnt += 1, saturating. The ID instruction is not lost, because upstream holds it via stall_o.
  - load: every ex_* field <= its id_* input; ex_valid <= id_valid. If id_valid = 0, all control bits are forced to 0 (data fields are still copied).
- Latency: 1 cycle ID to EX.
- A load-use stall lasts exactly 1 cycle. The bubble clears ex_mem_read, so hazard drops on the next cycle.
- Counters stop at 2^CNT_W - 1 and never wrap.
- Flush and hazard in the same cycle: a single flush is counted; bubble_cnt is unchanged and stall_o = 0.
- Reset in the middle of a stall: the next cycle has ex_valid = 0 and stall_o = 0, and the held ID instruction is re-presented normally.
- rd = x0 never causes a stall.
- Writes to x0 are not suppressed here. The RF and forwarding logic handle x0.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants: OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  - ALUOp constants: ALUOP_MEM = 00, ALUOP_BR = 01, ALUOP_ARITH = 10, ALUOP_JMP = 11
  - RWSel constants: RW_ALU = 00, RW_PC4 = 01, RW_IMM = 10, RW_PCIMM = 11
  - packed struct ctrl_t {alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op, branch, jalr_sel, rw_sel}, with constant CTRL_NOP = '0
- One sub-module, load_use_detect, is natural: purely combinational, takes opcode, indices, ex_mem_read, ex_rd, ex_valid and flush, and produces hazard and stall_o. The pipeline register and counters stay in id_ex_stage.

Test Plan:
1. Reset: hold reset for 2 cycles with random inputs -> all ex_* = 0, ex_valid = 0, counters 0, stall_o = 0. Load a valid add: ex_* matches the inputs 1 cycle later.
2. lw x5 in EX (ex_mem_read = 1, ex_rd = 5) and add x6,x5,x7 in ID -> stall_o = 1 for exactly 1 cycle; next ex_valid = 0 with controls 0; bubble_cnt = 1; the following edge loads the add with ex_valid = 1.
3. lw x0 in EX with add using x0 in ID -> stall_o = 0, no bubble. lw x5 with lui x5 in ID -> stall_o = 0. lw x5 with sw rs2 = 5 -> stall_o = 1. lw x5 with addi rs2 field = 5 -> stall_o = 0.
4. Hazard and flush in the same cycle -> stall_o = 0, bubble inserted, flush_cnt = 1, bubble_cnt unchanged.
5. Build with CNT_W = 2 and drive 5 hazard bubbles -> bubble_cnt sequence 1, 2, 3, 3, 3.
6. Assert reset while stall_o = 1 -> next cycle ex_valid = 0 and stall_o = 0. After reset falls, the re-presented add loads normally.
